xor3_parity_unit: RTL and testbench

- Bitwise 3-input XOR of three WIDTH-bit operands.
- Provides a purely combinational result, plus a registered result with valid flag, reduction parity and a running XOR accumulator.
- Used as a parity/checksum leaf in datapath blocks; with WIDTH=1 the combinational output is the classic 3-input XOR gate.

---
 rtl/xor3_parity_unit_pkg.sv | 10 +
 rtl/xor3_parity_unit_if.sv | 39 +++
 rtl/xor3_parity_unit_bit_slice.sv | 20 ++
 rtl/xor3_parity_unit.sv | 63 ++++++
 tb/tb_xor3_parity_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/xor3_parity_unit_pkg.sv
// Shared types and defaults for the 3-input XOR parity unit.
// Optional one-hot term is enabled by defining XOR3_ONEHOT_EN.
package xor3_pkg;

    localparam int DEF_WIDTH    = 1;
    localparam int DEF_ACC_INIT = 0;

    typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/xor3_parity_unit_if.sv
// Operand/result bundle between a driver and the XOR parity unit.
// The onehot_q signal exists only when XOR3_ONEHOT_EN is defined.
interface xor3_parity_unit_if
    import xor3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic [WIDTH-1:0] din_c;
    logic             in_valid;
    logic             acc_clr;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dout_q;
    logic             out_valid;
    logic             parity;
    logic [WIDTH-1:0] acc;
`ifdef XOR3_ONEHOT_EN
    logic [WIDTH-1:0] onehot_q;
`endif

    modport master (
        output din_a, din_b, din_c, in_valid, acc_clr,
        input  dout, dout_q, out_valid, parity, acc
`ifdef XOR3_ONEHOT_EN
        , input onehot_q
`endif
    );

    modport slave (
        input  din_a, din_b, din_c, in_valid, acc_clr,
        output dout, dout_q, out_valid, parity, acc
`ifdef XOR3_ONEHOT_EN
        , output onehot_q
`endif
    );

endinterface

// File: rtl/xor3_parity_unit_bit_slice.sv
// One bit of the 3-input XOR, plus the exactly-one-set term when
// XOR3_ONEHOT_EN is defined.
module xor3_bit_slice (
    input  logic a,
    input  logic b,
    input  logic c,
`ifdef XOR3_ONEHOT_EN
    output logic onehot,
`endif
    output logic y
);

    assign y = a ^ b ^ c;

`ifdef XOR3_ONEHOT_EN
    // Odd count with not all three set means exactly one input is high.
    assign onehot = (a ^ b ^ c) & ~(a & b & c);
`endif

endmodule

// File: rtl/xor3_parity_unit.sv
// Bitwise 3-input XOR with registered result, parity and running XOR
// accumulator. Define XOR3_ONEHOT_EN to add the registered onehot_q output.
module xor3_parity_unit
    import xor3_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] ACC_INIT = WIDTH'(DEF_ACC_INIT)
) (
    input logic               clk,
    input logic               rst_n,
    xor3_parity_unit_if.slave bus
);

    logic [WIDTH-1:0] xor_w;
`ifdef XOR3_ONEHOT_EN
    logic [WIDTH-1:0] onehot_w;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        xor3_bit_slice u_slice (
            .a      (bus.din_a[i]),
            .b      (bus.din_b[i]),
            .c      (bus.din_c[i]),
`ifdef XOR3_ONEHOT_EN
            .onehot (onehot_w[i]),
`endif
            .y      (xor_w[i])
        );
    end

    assign bus.dout   = xor_w;
    assign bus.parity = ^bus.dout_q;

    // Clear wins over accumulate, but the operand still lands in dout_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_q    <= '0;
            bus.out_valid <= 1'b0;
            bus.acc       <= ACC_INIT;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.dout_q <= xor_w;
            end
            if (bus.acc_clr) begin
                bus.acc <= ACC_INIT;
            end else if (bus.in_valid) begin
                bus.acc <= bus.acc ^ xor_w;
            end
        end
    end

`ifdef XOR3_ONEHOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.onehot_q <= '0;
        end else if (bus.in_valid) begin
            bus.onehot_q <= onehot_w;
        end
    end
`endif

endmodule

// File: tb/tb_xor3_parity_unit.sv
// Directed self-checking bench for xor3_parity_unit at WIDTH=1 and WIDTH=8.
// Onehot checks run only when XOR3_ONEHOT_EN is defined.
module tb_xor3_parity_unit;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    xor3_parity_unit_if #(.WIDTH(1)) if1 ();
    xor3_parity_unit_if #(.WIDTH(8)) if8 ();

    xor3_parity_unit #(.WIDTH(1), .ACC_INIT(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    xor3_parity_unit #(.WIDTH(8), .ACC_INIT(8'h00)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        #2;
        vectors++;
        if (if1.dout_q !== 1'b0 || if1.out_valid !== 1'b0 || if1.acc !== 1'b0 || if1.parity !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w1: dout_q=%b out_valid=%b acc=%b parity=%b, want 0 0 0 0",
                     if1.dout_q, if1.out_valid, if1.acc, if1.parity);
        end
        vectors++;
        if (if8.dout_q !== 8'h00 || if8.out_valid !== 1'b0 || if8.acc !== 8'h00 || if8.parity !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w8: dout_q=%h out_valid=%b acc=%h parity=%b, want 00 0 00 0",
                     if8.dout_q, if8.out_valid, if8.acc, if8.parity);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_truth_idle();
        logic [7:0] tbl;
        logic [2:0] v;
        tbl = 8'b1001_0110;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            if1.din_a = v[2]; if1.din_b = v[1]; if1.din_c = v[0];
            if1.in_valid = 1'b0;
            #1;
            vectors++;
            if (if1.dout !== tbl[i]) begin
                miscompares++;
                $display("FAIL truth_idle abc=%b: dout=%b want %b", v, if1.dout, tbl[i]);
            end
            @(posedge clk); #1;
            vectors++;
            if (if1.dout_q !== 1'b0 || if1.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold abc=%b: dout_q=%b out_valid=%b want 0 0", v, if1.dout_q, if1.out_valid);
            end
        end
    endtask

    task automatic test_truth_valid();
        logic [7:0] tbl;
        logic [2:0] v;
        tbl = 8'b1001_0110;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            if1.din_a = v[2]; if1.din_b = v[1]; if1.din_c = v[0];
            if1.in_valid = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (if1.dout_q !== tbl[i] || if1.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL truth_valid abc=%b: dout_q=%b out_valid=%b want %b 1",
                         v, if1.dout_q, if1.out_valid, tbl[i]);
            end
        end
        vectors++;
        if (if1.acc !== 1'b0) begin
            miscompares++;
            $display("FAIL acc_w1: acc=%b want 0", if1.acc);
        end
        @(negedge clk);
        if1.in_valid = 1'b0;
        if1.din_a = 1'b0; if1.din_b = 1'b0; if1.din_c = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (if1.dout_q !== 1'b1 || if1.out_valid !== 1'b0 || if1.acc !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_w1: dout_q=%b out_valid=%b acc=%b want 1 0 0",
                     if1.dout_q, if1.out_valid, if1.acc);
        end
    endtask

    task automatic test_w8_pulse();
        @(negedge clk);
        if8.din_a = 8'hF0; if8.din_b = 8'hCC; if8.din_c = 8'hAA;
        if8.in_valid = 1'b1;
        #1;
        vectors++;
        if (if8.dout !== 8'h96) begin
            miscompares++;
            $display("FAIL w8_comb: dout=%h want 96", if8.dout);
        end
        @(posedge clk); #1;
        vectors++;
        if (if8.dout_q !== 8'h96 || if8.parity !== 1'b0 || if8.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL w8_reg: dout_q=%h parity=%b out_valid=%b want 96 0 1",
                     if8.dout_q, if8.parity, if8.out_valid);
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (if8.out_valid !== 1'b0 || if8.dout_q !== 8'h96 || if8.acc !== 8'h96) begin
            miscompares++;
            $display("FAIL w8_pulse_end: out_valid=%b dout_q=%h acc=%h want 0 96 96",
                     if8.out_valid, if8.dout_q, if8.acc);
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] ops  [3];
        logic [7:0] accs [3];
        ops  = '{8'h01, 8'h02, 8'h04};
        accs = '{8'h01, 8'h03, 8'h07};
        @(negedge clk);
        if8.acc_clr = 1'b1; if8.in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (if8.acc !== 8'h00 || if8.dout_q !== 8'h96) begin
            miscompares++;
            $display("FAIL acc_clear_idle: acc=%h dout_q=%h want 00 96", if8.acc, if8.dout_q);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if8.acc_clr = 1'b0; if8.in_valid = 1'b1;
            if8.din_a = ops[i]; if8.din_b = 8'h00; if8.din_c = 8'h00;
            @(posedge clk); #1;
            vectors++;
            if (if8.acc !== accs[i] || if8.dout_q !== ops[i]) begin
                miscompares++;
                $display("FAIL acc_step%0d: acc=%h dout_q=%h want %h %h", i, if8.acc, if8.dout_q, accs[i], ops[i]);
            end
        end
        @(negedge clk);
        if8.acc_clr = 1'b1; if8.in_valid = 1'b1; if8.din_a = 8'h80;
        @(posedge clk); #1;
        vectors++;
        if (if8.acc !== 8'h00 || if8.dout_q !== 8'h80 || if8.out_valid !== 1'b1 || if8.parity !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_priority: acc=%h dout_q=%h out_valid=%b parity=%b want 00 80 1 1",
                     if8.acc, if8.dout_q, if8.out_valid, if8.parity);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        if8.acc_clr = 1'b0; if8.in_valid = 1'b1; if8.din_a = 8'h55;
        @(posedge clk); #1;
        vectors++;
        if (if8.acc !== 8'h55 || if8.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: acc=%h out_valid=%b want 55 1", if8.acc, if8.out_valid);
        end
        #2;
        rst_n = 1'b0;
        if8.din_a = 8'h0F; if8.din_b = 8'h30; if8.din_c = 8'h00;
        #1;
        vectors++;
        if (if8.dout_q !== 8'h00 || if8.out_valid !== 1'b0 || if8.acc !== 8'h00 || if8.parity !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: dout_q=%h out_valid=%b acc=%h parity=%b want 00 0 00 0",
                     if8.dout_q, if8.out_valid, if8.acc, if8.parity);
        end
        vectors++;
        if (if8.dout !== 8'h3F) begin
            miscompares++;
            $display("FAIL dout_in_reset: dout=%h want 3f", if8.dout);
        end
        @(negedge clk);
        if8.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

`ifdef XOR3_ONEHOT_EN
    task automatic test_onehot();
        logic [2:0] pats [2];
        logic       want [2];
        pats = '{3'b111, 3'b100};
        want = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if1.din_a = pats[i][2]; if1.din_b = pats[i][1]; if1.din_c = pats[i][0];
            if1.in_valid = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (if1.dout !== 1'b1 || if1.onehot_q !== want[i]) begin
                miscompares++;
                $display("FAIL onehot abc=%b: dout=%b onehot_q=%b want 1 %b", pats[i], if1.dout, if1.onehot_q, want[i]);
            end
        end
        @(negedge clk);
        if1.in_valid = 1'b0;
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        if1.din_a = '0; if1.din_b = '0; if1.din_c = '0; if1.in_valid = 1'b0; if1.acc_clr = 1'b0;
        if8.din_a = '0; if8.din_b = '0; if8.din_c = '0; if8.in_valid = 1'b0; if8.acc_clr = 1'b0;
        test_reset();
        test_truth_idle();
        test_truth_valid();
        test_w8_pulse();
        test_accumulate();
        test_async_reset();
`ifdef XOR3_ONEHOT_EN
        test_onehot();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
